// File: rtl/trace_pkg.sv
// Shared definitions for the register-writeback trace transmitter:
// header nibbles, frame layout, serializer states and the queued event record.
package trace_pkg;

  localparam logic [3:0] HDR_P1    = 4'hA;
  localparam logic [3:0] HDR_P2    = 4'hB;
  localparam int         FRAME_LEN = 6;
  localparam int         ENTRY_W   = 74;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    D0,
    D1,
    D2,
    D3,
    SUM
  } state_t;

  typedef struct packed {
    logic [1:0]  we;
    logic [3:0]  wa3;
    logic [31:0] wd3;
    logic [3:0]  wa3_2;
    logic [31:0] wd3_2;
  } entry_t;

  // Byte presented in serializer state st for the selected port of entry e.
  // SUM is the XOR of the header and the four little-endian data bytes.
  function automatic logic [7:0] frame_byte(state_t st, logic port2, entry_t e);
    logic [7:0]  hdr;
    logic [31:0] d;
    hdr = port2 ? {HDR_P2, e.wa3_2} : {HDR_P1, e.wa3};
    d   = port2 ? e.wd3_2 : e.wd3;
    case (st)
      HDR:     frame_byte = hdr;
      D0:      frame_byte = d[7:0];
      D1:      frame_byte = d[15:8];
      D2:      frame_byte = d[23:16];
      D3:      frame_byte = d[31:24];
      SUM:     frame_byte = hdr ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
      default: frame_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Single-clock FIFO with wrap-bit pointers and a fall-through head output.
module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 74
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;

  // Storage write; contents need no reset because the pointers gate visibility.
  // A push while full is only issued alongside a pop, so the slot being
  // overwritten is the one the head is leaving this same edge.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + (AW+1)'(1);
      if (pop_i)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  assign dout_o  = mem_q[rd_q[AW-1:0]];
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/wb_trace_tx.sv
// Register-writeback trace transmitter: captures register-file writes,
// queues them, and emits checksummed 6-byte frames on a valid/ready stream.
module wb_trace_tx
  import trace_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trace_en,
  input  logic [1:0]        we,
  input  logic [3:0]        wa3,
  input  logic [31:0]       wd3,
  input  logic [3:0]        wa3_2,
  input  logic [31:0]       wd3_2,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count
);

  logic               push_req;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [ENTRY_W-1:0] fifo_din;
  logic [ENTRY_W-1:0] fifo_dout;
  entry_t             head;

  state_t             state_q, state_d;
  logic               port2_q, port2_d;
  entry_t             hold_q, hold_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               overflow_q;
  logic [DROP_W-1:0]  drop_q;

  assign push_req = trace_en && (we != 2'b00);
  // A full FIFO still accepts when the serializer pops on the same edge.
  assign push     = push_req && (!full || pop);
  assign fifo_din = {we, wa3, wd3, wa3_2, wd3_2};
  assign head     = entry_t'(fifo_dout);

  trace_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk    (clk),
    .rst    (reset),
    .push_i (push),
    .din_i  (fifo_din),
    .pop_i  (pop),
    .dout_o (fifo_dout),
    .full_o (full),
    .empty_o(empty)
  );

  // Sticky overflow flag and saturating count of rejected events.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else if (push_req && !push) begin
      overflow_q <= 1'b1;
      if (drop_q != '1) drop_q <= drop_q + DROP_W'(1);
    end
  end

  // Serializer next-state: IDLE pops into the holding register; the first
  // cycle in HDR loads the header byte, after which each accepted byte
  // loads the next one so the stream runs without gaps inside an entry.
  always_comb begin
    state_d    = state_q;
    port2_d    = port2_q;
    hold_d     = hold_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    pop        = 1'b0;
    if (state_q == IDLE) begin
      tx_valid_d = 1'b0;
      if (!empty) begin
        pop     = 1'b1;
        hold_d  = head;
        port2_d = !head.we[0];
        state_d = HDR;
      end
    end else if (!tx_valid_q) begin
      tx_valid_d = 1'b1;
      tx_data_d  = frame_byte(state_q, port2_q, hold_q);
    end else if (tx_ready) begin
      if (state_q == SUM) begin
        if (!port2_q && hold_q.we[1]) begin
          state_d   = HDR;
          port2_d   = 1'b1;
          tx_data_d = frame_byte(HDR, 1'b1, hold_q);
        end else begin
          state_d    = IDLE;
          tx_valid_d = 1'b0;
        end
      end else begin
        state_d   = state_t'(state_q + 3'd1);
        tx_data_d = frame_byte(state_t'(state_q + 3'd1), port2_q, hold_q);
      end
    end
  end

  // Serializer state and registered stream outputs; reset abandons any frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      port2_q    <= 1'b0;
      hold_q     <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      port2_q    <= port2_d;
      hold_q     <= hold_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_wb_trace_tx.sv
// Directed bench for wb_trace_tx: table of single/dual write events with
// hand-computed frames, plus latency, backpressure, overflow, reset and
// capture-disable sequences.
module tb_wb_trace_tx;

  localparam int DEPTH  = 8;
  localparam int DROP_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              trace_en;
  logic [1:0]        we;
  logic [3:0]        wa3;
  logic [31:0]       wd3;
  logic [3:0]        wa3_2;
  logic [31:0]       wd3_2;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              overflow;
  logic [DROP_W-1:0] drop_count;

  wb_trace_tx #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .trace_en  (trace_en),
    .we        (we),
    .wa3       (wa3),
    .wd3       (wd3),
    .wa3_2     (wa3_2),
    .wd3_2     (wd3_2),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .overflow  (overflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  we;
    logic [3:0]  a1;
    logic [31:0] d1;
    logic [3:0]  a2;
    logic [31:0] d2;
    int          nb;
    logic [7:0]  exp [12];
  } vec_t;

  vec_t vecs [5];

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [7:0] rx_q [$];
  int         rx_t [$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stream monitor: records accepted bytes with their cycle number and
  // checks that a stalled byte is held stable with valid still high.
  initial begin
    logic       stall_prev;
    logic [7:0] data_prev;
    stall_prev = 1'b0;
    data_prev  = 8'h00;
    forever begin
      @(posedge clk);
      if (reset) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("stall_valid", tx_valid, 1);
          chk("stall_data", tx_data, data_prev);
        end
        if (tx_valid && tx_ready) begin
          rx_q.push_back(tx_data);
          rx_t.push_back(cyc);
        end
        stall_prev = tx_valid && !tx_ready;
        data_prev  = tx_data;
      end
      cyc++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one capture event for a single edge, starting and ending at a negedge.
  task automatic send(logic [1:0] w, logic [3:0] a1, logic [31:0] d1,
                      logic [3:0] a2, logic [31:0] d2);
    we = w; wa3 = a1; wd3 = d1; wa3_2 = a2; wd3_2 = d2;
    @(negedge clk);
    we = 2'b00;
  endtask

  task automatic wait_bytes(int n, int budget, bit toggle);
    int t;
    t = 0;
    while (rx_q.size() < n && t < budget) begin
      @(negedge clk);
      if (toggle) tx_ready = ~tx_ready;
      t++;
    end
    chk("byte_count", rx_q.size(), n);
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_t.delete();
  endtask

  initial begin
    vecs[0].we = 2'b01; vecs[0].a1 = 4'h0; vecs[0].d1 = 32'd10;
    vecs[0].a2 = 4'h0;  vecs[0].d2 = 32'h0; vecs[0].nb = 6;
    vecs[0].exp = '{8'hA0, 8'h0A, 8'h00, 8'h00, 8'h00, 8'hAA,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[1].we = 2'b11; vecs[1].a1 = 4'h2; vecs[1].d1 = 32'h12345678;
    vecs[1].a2 = 4'h3;  vecs[1].d2 = 32'h1; vecs[1].nb = 12;
    vecs[1].exp = '{8'hA2, 8'h78, 8'h56, 8'h34, 8'h12, 8'hAA,
                    8'hB3, 8'h01, 8'h00, 8'h00, 8'h00, 8'hB2};
    vecs[2].we = 2'b10; vecs[2].a1 = 4'hE; vecs[2].d1 = 32'hFFFFFFFF;
    vecs[2].a2 = 4'h5;  vecs[2].d2 = 32'h01020304; vecs[2].nb = 6;
    vecs[2].exp = '{8'hB5, 8'h04, 8'h03, 8'h02, 8'h01, 8'hB1,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[3].we = 2'b01; vecs[3].a1 = 4'hF; vecs[3].d1 = 32'hFFFFFFFF;
    vecs[3].a2 = 4'h0;  vecs[3].d2 = 32'h0; vecs[3].nb = 6;
    vecs[3].exp = '{8'hAF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hAF,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[4].we = 2'b11; vecs[4].a1 = 4'h7; vecs[4].d1 = 32'hDEADBEEF;
    vecs[4].a2 = 4'h1;  vecs[4].d2 = 32'h80000000; vecs[4].nb = 12;
    vecs[4].exp = '{8'hA7, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h85,
                    8'hB1, 8'h00, 8'h00, 8'h00, 8'h80, 8'h31};

    reset = 1'b1; trace_en = 1'b1; we = 2'b00; wa3 = 4'h0; wd3 = 32'h0;
    wa3_2 = 4'h0; wd3_2 = 32'h0; tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop", drop_count, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Latency: capture at edge k, nothing after k+1, header after k+2.
    clear_rx();
    we = 2'b01; wa3 = 4'h0; wd3 = 32'd10;
    @(posedge clk);
    @(negedge clk);
    we = 2'b00;
    @(posedge clk); #1;
    chk("lat_k1_valid", tx_valid, 0);
    @(posedge clk); #1;
    chk("lat_k2_valid", tx_valid, 1);
    chk("lat_k2_hdr", tx_data, 8'hA0);
    @(negedge clk);
    wait_bytes(6, 50, 1'b0);
    for (int b = 0; b < 6; b++)
      if (b < rx_q.size()) chk($sformatf("lat_b%0d", b), rx_q[b], vecs[0].exp[b]);
    repeat (3) @(negedge clk);
    chk("lat_idle", tx_valid, 0);

    // Table of directed events with full frame comparison.
    for (int v = 0; v < 5; v++) begin
      clear_rx();
      send(vecs[v].we, vecs[v].a1, vecs[v].d1, vecs[v].a2, vecs[v].d2);
      wait_bytes(vecs[v].nb, 100, 1'b0);
      for (int b = 0; b < vecs[v].nb; b++)
        if (b < rx_q.size()) chk($sformatf("v%0d_b%0d", v, b), rx_q[b], vecs[v].exp[b]);
      if (vecs[v].nb == 12 && rx_t.size() >= 12)
        chk($sformatf("v%0d_no_gap", v), rx_t[6] - rx_t[5], 1);
      repeat (4) @(negedge clk);
      chk($sformatf("v%0d_idle", v), tx_valid, 0);
    end

    // Backpressure: ready toggles every cycle; bytes identical and held stable.
    clear_rx();
    tx_ready = 1'b0;
    send(vecs[0].we, vecs[0].a1, vecs[0].d1, vecs[0].a2, vecs[0].d2);
    wait_bytes(6, 100, 1'b1);
    for (int b = 0; b < 6; b++)
      if (b < rx_q.size()) chk($sformatf("bp_b%0d", b), rx_q[b], vecs[0].exp[b]);
    tx_ready = 1'b1;
    repeat (4) @(negedge clk);

    // Overflow: 11 back-to-back events with the sink stalled.
    clear_rx();
    tx_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      we = 2'b01; wa3 = 4'(i); wd3 = 32'(100 + i);
      @(negedge clk);
    end
    we = 2'b00;
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop", drop_count, 2);
    repeat (5) @(negedge clk);
    chk("ovf_sticky", overflow, 1);
    tx_ready = 1'b1;
    wait_bytes(54, 2000, 1'b0);
    for (int f = 0; f < 9; f++) begin
      if (f * 6 + 1 < rx_q.size()) begin
        chk($sformatf("ovf_f%0d_hdr", f), rx_q[f*6], {4'hA, 4'(f)});
        chk($sformatf("ovf_f%0d_d0", f), rx_q[f*6+1], 8'(100 + f));
      end
    end
    repeat (20) @(negedge clk);
    chk("ovf_frames", rx_q.size(), 54);
    chk("ovf_drop_final", drop_count, 2);

    // Reset asserted mid-frame after the third byte.
    clear_rx();
    send(2'b01, 4'h4, 32'hCAFEF00D, 4'h0, 32'h0);
    send(2'b01, 4'h6, 32'h0BADBEEF, 4'h0, 32'h0);
    wait_bytes(3, 50, 1'b0);
    #1 reset = 1'b1;
    #1;
    chk("rstmid_valid", tx_valid, 0);
    chk("rstmid_overflow", overflow, 0);
    chk("rstmid_drop", drop_count, 0);
    @(negedge clk);
    reset = 1'b0;
    clear_rx();
    repeat (12) @(negedge clk);
    chk("rstmid_empty", rx_q.size(), 0);
    send(2'b01, 4'h9, 32'h00000055, 4'h0, 32'h0);
    wait_bytes(6, 50, 1'b0);
    begin
      logic [7:0] fresh [6];
      fresh = '{8'hA9, 8'h55, 8'h00, 8'h00, 8'h00, 8'hFC};
      for (int b = 0; b < 6; b++)
        if (b < rx_q.size()) chk($sformatf("rstmid_b%0d", b), rx_q[b], fresh[b]);
    end
    repeat (4) @(negedge clk);

    // Capture disabled: writes are neither queued nor counted as drops.
    clear_rx();
    trace_en = 1'b0;
    we = 2'b01; wa3 = 4'h3; wd3 = 32'h77;
    repeat (5) @(negedge clk);
    we = 2'b00;
    repeat (10) @(negedge clk);
    chk("dis_frames", rx_q.size(), 0);
    chk("dis_drop", drop_count, 0);
    chk("dis_valid", tx_valid, 0);
    trace_en = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
